// File: rtl/serial_adder_nbit.sv
// Multi-cycle ripple adder: adds a + b + cin DIGIT bits per clock, LSB first, via DIGIT full-adder cells.
// Latency: start accepted at edge k -> done pulses after edge k+N (N = WIDTH/DIGIT), N+1 cycles per result.
// Backpressure: none; start is only accepted in IDLE or DONE, ignored while busy.
module serial_adder_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             load;
    logic             step;
    logic             finish;
    logic             last;

    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0]   c;

    assign last = (cnt == CW'(N - 1));

    // Ripple chain of DIGIT full-adder cells over the low digit of each operand.
    assign c[0] = carry;
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign dsum[i]  = a_sh[i] ^ b_sh[i] ^ c[i];
        assign c[i+1]   = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
    end

    // New digit enters at the MSB end so the completed word is aligned after N steps.
    if (DIGIT == WIDTH) begin : g_sum_full
        assign sum_nxt = dsum;
    end else begin : g_sum_shift
        assign sum_nxt = {dsum, sum_sh[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (step) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            sum_sh <= sum_nxt;
            carry  <= c[DIGIT];
            cnt    <= cnt + CW'(1);
            // On the final digit the top cell of the chain is bit WIDTH-1.
            if (finish) begin
                sum_q  <= sum_nxt;
                cout_q <= c[DIGIT];
                ovf_q  <= c[DIGIT-1] ^ c[DIGIT];
            end
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed bench for serial_adder_nbit in three configurations: 8/1, 4/2 (exhaustive), 8/8.
module tb_serial_adder_nbit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    logic       startx = 1'b0, cinx = 1'b0;
    logic [7:0] ax = '0, bx = '0;
    logic       busyx, donex, coutx, ovfx;
    logic [7:0] sumx;

    serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    serial_adder_nbit #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
    );

    serial_adder_nbit #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
        .clk(clk), .rst(rst), .start(startx), .a(ax), .b(bx), .cin(cinx),
        .busy(busyx), .done(donex), .sum(sumx), .cout(coutx), .overflow(ovfx)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ndone = 0;
    logic [9:0] prev8 = '0;   // {cout, overflow, sum} the 8/1 instance must be holding
    logic [3:0] ea, eb;
    logic       ec;
    logic [4:0] r5;
    int         ss;
    logic       eovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full 8/1 transaction from IDLE; operands scrambled during RUN.
    task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [7:0] es, input logic ec8, input logic eo8);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~ta; b8 = ~tb; cin8 = ~tc;
        check({tag, "/accept"}, 32'({busy8, done8, cout8, ovf8, sum8}), 32'({2'b10, prev8}));
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            check({tag, "/run"}, 32'({busy8, done8, cout8, ovf8, sum8}), 32'({2'b10, prev8}));
        end
        @(posedge clk); #1;
        check({tag, "/done"}, 32'({busy8, done8, cout8, ovf8, sum8}), 32'({2'b01, ec8, eo8, es}));
        prev8 = {ec8, eo8, es};
        @(posedge clk); #1;
        check({tag, "/idle"}, 32'({busy8, done8, cout8, ovf8, sum8}), 32'({2'b00, prev8}));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_w8d1", 32'({busy8, done8, cout8, ovf8, sum8}), 32'd0);
        check("reset_w4d2", 32'({busy4, done4, cout4, ovf4, sum4}), 32'd0);
        check("reset_w8d8", 32'({busyx, donex, coutx, ovfx, sumx}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run8("5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run8("ff_00_c1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run8("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run8("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // A second start during RUN must be ignored.
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
            if (i == 3) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
            end else if (i == 4) begin
                start8 = 1'b0;
            end
            if (i == 6)
                check("midstart/run", 32'({busy8, done8, cout8, ovf8, sum8}), 32'({2'b10, prev8}));
            if (i == 8)
                check("midstart/done", 32'({busy8, done8, cout8, ovf8, sum8}), 32'({2'b01, 2'b00, 8'h33}));
        end
        check("midstart/ndone", 32'(ndone), 32'd1);
        check("midstart/idle", 32'({busy8, done8}), 32'd0);
        prev8 = {2'b00, 8'h33};

        // Reset during RUN aborts without a done pulse.
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort/reset", 32'({busy8, done8, cout8, ovf8, sum8}), 32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) ndone++;
        end
        check("abort/quiet", 32'(ndone), 32'd0);
        prev8 = '0;
        run8("f0_0f_c1", 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0);

        // 4/2: all 512 operand combinations back to back with start held high.
        start4 = 1'b1;
        for (int j = 0; j < 512; j++) begin
            ea = 4'(j >> 5); eb = 4'(j >> 1); ec = j[0];
            a4 = ea; b4 = eb; cin4 = ec;
            @(posedge clk); #1;
            check("w4/accept", 32'({busy4, done4}), 32'b10);
            @(posedge clk); #1;
            check("w4/run", 32'({busy4, done4}), 32'b10);
            @(posedge clk); #1;
            r5 = 5'(ea) + 5'(eb) + 5'(ec);
            ss = int'($signed(ea)) + int'($signed(eb)) + int'(ec);
            eovf = (ss > 7) || (ss < -8);
            check("w4/done", 32'({busy4, done4, cout4, ovf4, sum4}),
                  32'({2'b01, r5[4], eovf, r5[3:0]}));
        end
        start4 = 1'b0;
        @(posedge clk); #1;
        check("w4/idle", 32'({busy4, done4}), 32'd0);

        // 8/8: single RUN cycle.
        ax = 8'h01; bx = 8'h01; cinx = 1'b1; startx = 1'b1;
        @(posedge clk); #1;
        startx = 1'b0;
        check("w8d8/accept", 32'({busyx, donex, coutx, ovfx, sumx}), 32'({2'b10, 10'd0}));
        @(posedge clk); #1;
        check("w8d8/done", 32'({busyx, donex, coutx, ovfx, sumx}), 32'({2'b01, 2'b00, 8'h03}));
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if ({busyx, donex, coutx, ovfx, sumx} !== {4'b0000, 8'h03}) ndone++;
        end
        check("w8d8/hold", 32'(ndone), 32'd0);
        ax = 8'h40; bx = 8'h40; cinx = 1'b0; startx = 1'b1;
        @(posedge clk); #1;
        startx = 1'b0;
        @(posedge clk); #1;
        check("w8d8/40_40", 32'({busyx, donex, coutx, ovfx, sumx}), 32'({2'b01, 2'b01, 8'h80}));
        ax = 8'hFF; bx = 8'h01; cinx = 1'b0; startx = 1'b1;
        @(posedge clk); #1;
        startx = 1'b0;
        @(posedge clk); #1;
        check("w8d8/ff_01", 32'({busyx, donex, coutx, ovfx, sumx}), 32'({2'b01, 2'b10, 8'h00}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_nbit.md
Name: serial_adder_nbit

Overview:
- Parametrised multi-cycle adder built from full-adder slices.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB first.
- Uses a start/busy/done handshake.
- Successor to the single-bit combinational full adder. It serves datapaths that trade latency for area, since only DIGIT full-adder cells are instantiated.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 2.
- DIGIT, 1, bits added per cycle; must divide WIDTH exactly, range 1..WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled with accepted start.
- b  input  WIDTH  operand B; sampled with accepted start.
- cin  input  1  carry-in; sampled with accepted start.
- busy  output  1  high while a calculation is in RUN.
- done  output  1  single-cycle pulse; result registers just updated.
- sum  output  WIDTH  result (a + b + cin) mod 2^WIDTH.
- cout  output  1  unsigned carry out of MSB.
- overflow  output  1  two's-complement overflow: carry into MSB XOR cout.

Behaviour:
- Reset: on a clk edge with rst=1, state=IDLE and every output and internal register is 0. This applies in any state and overrides start. A calculation in flight is aborted and produces no done pulse.
- N = WIDTH/DIGIT, the number of RUN cycles.
- States:
  - IDLE: busy=0, done=0. start=1 at edge k loads shift registers from a and b, loads carry register with cin, clears the digit counter, and moves to RUN. busy=1 from edge k.
  - RUN: each edge adds the DIGIT LSBs of both shift registers plus the carry register through a DIGIT-cell ripple chain. The DIGIT-bit result shifts into the MSB end of the internal sum shift register. Both operand registers shift right by DIGIT, the carry register takes the chain carry-out, and the counter increments.
  - RUN, final digit: on the edge processing digit N-1 (edge k+N), load sum, cout and overflow from the completed result and move to DONE. busy=0 and done=1 from edge k+N.
  - DONE: lasts exactly one cycle. start=1 at its closing edge is accepted exactly as in IDLE (back-to-back operation; busy=1 next cycle, done=0). Otherwise go to IDLE.
- Latency: start accepted at edge k gives done high in the cycle following edge k+N, i.e. N+1 clocks from start assertion to done observed.
- Throughput with start held high: one result every N+1 cycles.
- start while in RUN is ignored. a, b and cin may change freely during RUN without affecting the result.
- Outputs sum, cout and overflow change only at completion edges or reset. They hold the last result through IDLE and through the whole next RUN.
- overflow uses the carry into bit WIDTH-1, captured inside the final digit's ripple chain; when DIGIT=1 it is the carry register value entering the final cycle.
- Width rules: no width extension of the output; the carry beyond WIDTH appears only on cout. The counter is $clog2(N) bits, minimum 1.
- DIGIT=WIDTH is legal: one RUN cycle, 2-clock latency.

Test Plan:
- WIDTH=8, DIGIT=1, a=0x5A, b=0x3C, cin=0, start one cycle → busy high 8 cycles, done pulses once 9 clocks after start; sum=0x96, cout=0, overflow=1.
- WIDTH=8, DIGIT=1: 0xFF+0x00 cin=1 → sum=0x00, cout=1, overflow=0. Then 0x80+0x80 cin=0 → sum=0x00, cout=1, overflow=1. Then 0x7F+0x01 cin=0 → sum=0x80, cout=0, overflow=1.
- WIDTH=4, DIGIT=2, exhaustive over all 512 {a,b,cin} combinations, start held high → done every 3 cycles. Each sum/cout matches a+b+cin, and overflow matches the signed-range check. No missed or duplicated done pulses.
- Start with a=0x11, b=0x22; mid-RUN pulse start with a=0xFF, b=0xFF and also change a/b → the second start is ignored; result is sum=0x33, cout=0; exactly one done.
- Start with a=0xF0, b=0x0F, cin=1; assert rst for one cycle at RUN cycle 4 → next cycle state IDLE, busy=0, sum=0, cout=0, overflow=0, no done. A fresh start then completes normally: sum=0x00, cout=1.
- WIDTH=8, DIGIT=8: a=0x01, b=0x01, cin=1 → done 2 clocks after start; sum=0x03; outputs stable for 20 idle cycles afterwards.
